// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM states, ACK levels, counter width.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int unsigned CNT_W = 4;

  // General call (address 0) never matches.
  function automatic logic addr_match(input logic [7:0] frame, input logic [6:0] addr);
    return (frame[7:1] == addr) && (frame[7:1] != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// Bus and byte-handshake signals between an I2C controller side and the target.
interface i2c_target_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;

  modport master (
    output scl, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_load, busy
  );

  modport slave (
    input  scl, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_load, busy
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer plus history flop; reports rise/fall of the synchronized level.
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  // Reset to 1 so an idle bus produces no edges when reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '1;
      hist  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      hist  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/i2c_target.sv
// I2C target with 7-bit address match, byte receive with ACK, and byte transmit with tx_load handshake.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  ADDR        = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         reset,
  i2c_target_if.slave bus
);

  logic scl_q, scl_rise, scl_fall;
  logic sda_q, sda_rise, sda_fall;
  logic start, stop;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .reset(reset), .d(bus.scl),
    .q(scl_q), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .reset(reset), .d(bus.sda_in),
    .q(sda_q), .rise(sda_rise), .fall(sda_fall)
  );

  assign start = sda_fall & scl_q;
  assign stop  = sda_rise & scl_q;

  state_t           state, state_n;
  logic             phase, phase_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       frame;
  logic             rw, rw_n;
  logic             oe, oe_n;
  logic [7:0]       rx_data_q, rx_data_n;
  logic             rx_valid_q, rx_valid_n;
  logic             tx_load_q, tx_load_n;

  assign frame = {shreg[6:0], sda_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
    end
  end

  // phase marks the second scl_fall of ACK slots, and a received ACK in TX_ACK.
  always_comb begin
    state_n = state;
    phase_n = phase;
    if (start) begin
      state_n = ST_ADDR;
      phase_n = 1'b0;
    end else if (stop) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise && cnt == CNT_W'(7)) begin
          state_n = addr_match(frame, ADDR) ? ST_ADDR_ACK : ST_IGNORE;
          phase_n = 1'b0;
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!phase) phase_n = 1'b1;
          else        state_n = rw ? ST_TX : ST_RX;
        end
        ST_RX: if (scl_rise && cnt == CNT_W'(7)) begin
          state_n = ST_RX_ACK;
          phase_n = 1'b0;
        end
        ST_RX_ACK: if (scl_fall) begin
          if (!phase) phase_n = 1'b1;
          else        state_n = ST_RX;
        end
        ST_TX: if (scl_fall && cnt == CNT_W'(8)) begin
          state_n = ST_TX_ACK;
          phase_n = 1'b0;
        end
        ST_TX_ACK: begin
          if (!phase && scl_rise) begin
            if (sda_q == ACK) phase_n = 1'b1;
            else              state_n = ST_IGNORE;
          end else if (phase && scl_fall) begin
            state_n = ST_TX;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    oe_n       = oe;
    cnt_n      = cnt;
    shreg_n    = shreg;
    rw_n       = rw;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    tx_load_n  = 1'b0;
    if (start) begin
      oe_n  = 1'b0;
      cnt_n = '0;
    end else if (stop) begin
      oe_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          shreg_n = frame;
          cnt_n   = cnt + 1'b1;
          rw_n    = sda_q;
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!phase) begin
            oe_n = 1'b1;
          end else if (rw) begin
            tx_load_n = 1'b1;
            shreg_n   = bus.tx_data;
            oe_n      = ~bus.tx_data[7];
            cnt_n     = CNT_W'(1);
          end else begin
            oe_n  = 1'b0;
            cnt_n = '0;
          end
        end
        ST_RX: if (scl_rise) begin
          shreg_n = frame;
          cnt_n   = cnt + 1'b1;
          if (cnt == CNT_W'(7)) begin
            rx_data_n  = frame;
            rx_valid_n = 1'b1;
          end
        end
        ST_RX_ACK: if (scl_fall) begin
          oe_n = !phase;
          if (phase) cnt_n = '0;
        end
        // cnt counts bits already driven; the bit after the load is bit 6.
        ST_TX: if (scl_fall) begin
          if (cnt == CNT_W'(8)) begin
            oe_n = 1'b0;
          end else begin
            oe_n    = ~shreg[6];
            shreg_n = {shreg[6:0], 1'b0};
            cnt_n   = cnt + 1'b1;
          end
        end
        ST_TX_ACK: if (phase && scl_fall) begin
          tx_load_n = 1'b1;
          shreg_n   = bus.tx_data;
          oe_n      = ~bus.tx_data[7];
          cnt_n     = CNT_W'(1);
        end
        default: oe_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oe         <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      rw         <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
    end else begin
      oe         <= oe_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      rw         <= rw_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
      tx_load_q  <= tx_load_n;
    end
  end

  assign bus.sda_oe   = oe;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_load  = tx_load_q;
  assign bus.busy     = state inside {ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK};

endmodule

// File: tb/tb_i2c_target.sv
// Directed-vector bench for i2c_target: bit-banged controller on an open-drain SDA model.
module tb_i2c_target;

  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  logic ctrl_sda;
  logic override;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int oe_cycles = 0;

  i2c_target_if bus ();

  // override lets the controller drive the pad directly, modelling a bus fault.
  assign bus.sda_in = override ? ctrl_sda : (ctrl_sda & ~bus.sda_oe);

  i2c_target #(.ADDR(7'h50), .SYNC_STAGES(SYNC)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rx_valid) rx_cnt <= rx_cnt + 1;
    if (bus.tx_load)  tx_cnt <= tx_cnt + 1;
    if (bus.sda_oe)   oe_cycles <= oe_cycles + 1;
  end

  task automatic clock_bit(input logic b, output logic seen);
    #100 ctrl_sda = b;
    #100 bus.scl = 1'b1;
    #100 seen = bus.sda_in;
    #100 bus.scl = 1'b0;
  endtask

  task automatic start_cond();
    ctrl_sda = 1'b1;
    #100 bus.scl = 1'b1;
    #100 ctrl_sda = 1'b0;
    #100 bus.scl = 1'b0;
    #100;
  endtask

  task automatic stop_cond();
    ctrl_sda = 1'b0;
    #100 bus.scl = 1'b1;
    #100 ctrl_sda = 1'b1;
    #100;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      b = {b[6:0], s};
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    override    = 1'b0;
    ctrl_sda    = 1'b1;
    bus.scl     = 1'b1;
    bus.tx_data = 8'h00;
    #52 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", bus.sda_oe); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
    checks++; if (bus.tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load: got %b expected 0", bus.tx_load); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_write();
    logic s;
    int   rx0;
    rx0 = rx_cnt;
    start_cond();
    send_byte(8'hA0);
    clock_bit(1'b1, s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b expected 0", s); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", bus.busy); end
    send_byte(8'h3C);
    clock_bit(1'b1, s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL write_data_ack: got %b expected 0", s); end
    checks++; if (rx_cnt - rx0 !== 1) begin errors++; $display("FAIL write_rx_valid_count: got %0d expected 1", rx_cnt - rx0); end
    checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL write_rx_data: got %h expected 3c", bus.rx_data); end
    stop_cond();
    #100;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b expected 0", bus.busy); end
  endtask

  task automatic test_wrong_addr();
    logic s;
    int   rx0, oe0;
    rx0 = rx_cnt;
    oe0 = oe_cycles;
    start_cond();
    send_byte(8'hA2);
    clock_bit(1'b1, s);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL wrong_addr_nack: got %b expected 1", s); end
    send_byte(8'h3C);
    clock_bit(1'b1, s);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy: got %b expected 0", bus.busy); end
    checks++; if (oe_cycles - oe0 !== 0) begin errors++; $display("FAIL wrong_addr_oe: got %0d driven cycles expected 0", oe_cycles - oe0); end
    checks++; if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL wrong_addr_rx_valid: got %0d expected 0", rx_cnt - rx0); end
    stop_cond();
    #100;
  endtask

  task automatic test_read();
    logic       s;
    logic [7:0] b;
    int         tx0;
    bus.tx_data = 8'hC5;
    tx0 = tx_cnt;
    start_cond();
    send_byte(8'hA1);
    clock_bit(1'b1, s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b expected 0", s); end
    read_byte(b);
    checks++; if (b !== 8'hC5) begin errors++; $display("FAIL read_byte1: got %h expected c5", b); end
    checks++; if (tx_cnt - tx0 !== 1) begin errors++; $display("FAIL read_tx_load1: got %0d expected 1", tx_cnt - tx0); end
    clock_bit(1'b0, s);
    read_byte(b);
    checks++; if (b !== 8'hC5) begin errors++; $display("FAIL read_byte2: got %h expected c5", b); end
    checks++; if (tx_cnt - tx0 !== 2) begin errors++; $display("FAIL read_tx_load2: got %0d expected 2", tx_cnt - tx0); end
    clock_bit(1'b1, s);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL read_nack_released: got %b expected 1", s); end
    #100;
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL read_oe_after_nack: got %b expected 0", bus.sda_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_nack: got %b expected 0", bus.busy); end
    stop_cond();
    #100;
  endtask

  task automatic test_rep_start();
    logic       s;
    logic [7:0] b;
    int         rx0;
    rx0 = rx_cnt;
    bus.tx_data = 8'h69;
    start_cond();
    send_byte(8'hA0);
    clock_bit(1'b1, s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL rep_first_ack: got %b expected 0", s); end
    clock_bit(1'b1, s);
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    start_cond();
    send_byte(8'hA1);
    clock_bit(1'b1, s);
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL rep_second_ack: got %b expected 0", s); end
    read_byte(b);
    checks++; if (b !== 8'h69) begin errors++; $display("FAIL rep_read_byte: got %h expected 69", b); end
    checks++; if (rx_cnt - rx0 !== 0) begin errors++; $display("FAIL rep_no_rx_valid: got %0d expected 0", rx_cnt - rx0); end
    clock_bit(1'b1, s);
    stop_cond();
    #100;
  endtask

  task automatic test_stop_in_tx();
    logic       s;
    logic [3:0] nib;
    int         lat;
    bus.tx_data = 8'hC5;
    start_cond();
    send_byte(8'hA1);
    clock_bit(1'b1, s);
    nib = '0;
    for (int i = 0; i < 4; i++) begin
      clock_bit(1'b1, s);
      nib = {nib[2:0], s};
    end
    checks++; if (nib !== 4'hC) begin errors++; $display("FAIL stop_tx_upper_nibble: got %h expected c", nib); end
    #100;
    checks++; if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL stop_tx_bit3_driven: got %b expected 1", bus.sda_oe); end
    ctrl_sda = 1'b0;
    override = 1'b1;
    #100 bus.scl = 1'b1;
    #100 ctrl_sda = 1'b1;
    lat = 0;
    while (bus.sda_oe && lat < int'(SYNC + 2)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL stop_tx_release: got %b after %0d clk expected 0", bus.sda_oe, lat); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_tx_idle: got busy %b expected 0", bus.busy); end
    override = 1'b0;
    #100;
  endtask

  task automatic test_reset_mid_ack();
    logic s;
    start_cond();
    send_byte(8'hA0);
    clock_bit(1'b1, s);
    send_byte(8'h5A);
    #60;
    checks++; if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL rst_ack_pre_oe: got %b expected 1", bus.sda_oe); end
    checks++; if (bus.rx_data !== 8'h5A) begin errors++; $display("FAIL rst_ack_pre_rx_data: got %h expected 5a", bus.rx_data); end
    #3 reset = 1'b1;
    #1;
    checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rst_ack_oe: got %b expected 0", bus.sda_oe); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL rst_ack_rx_data: got %h expected 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_rx_valid: got %b expected 0", bus.rx_valid); end
    checks++; if (bus.tx_load !== 1'b0) begin errors++; $display("FAIL rst_ack_tx_load: got %b expected 0", bus.tx_load); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_ack_busy: got %b expected 0", bus.busy); end
    bus.scl  = 1'b1;
    ctrl_sda = 1'b1;
    #50 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.sda_oe !== 1'b0) begin
      errors++; $display("FAIL rst_release_quiet: got busy %b oe %b expected 0 0", bus.busy, bus.sda_oe);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_rep_start();
    test_stop_in_tx();
    test_reset_mid_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDR, default 7'h50, is the 7-bit target address matched after START.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth on scl and sda_in (minimum 2).
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scl  input  1  bus clock from the controller (asynchronous).
REQ-006 sda_in  input  1  bus data as read from the pad (asynchronous).
REQ-007 sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain).
REQ-008 rx_data  output  8  last byte written by the controller, MSB first.
REQ-009 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-010 tx_data  input  8  byte to return on a read; sampled when tx_load pulses.
REQ-011 tx_load  output  1  one-cycle pulse, tx_data captured into the shift register.
REQ-012 busy  output  1  high from addressed START until STOP or NACK-release.

Function
REQ-013 scl and sda_in pass through SYNC_STAGES flops plus one history flop; events are scl_rise, scl_fall, sda_rise, sda_fall on synchronized values.
REQ-014 START = sda_fall while scl high; STOP = sda_rise while scl high; both are honoured in every state and take priority over bit events in the same cycle.
REQ-015 Data bits are sampled on scl_rise; sda_oe changes only on scl_fall (never while scl high).
REQ-016 States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
REQ-017 START (including repeated START) -> ADDR, bit counter cleared, sda_oe = 0.
REQ-018 ADDR shifts 8 bits (7 address + R/W); on the 8th scl_rise, match -> ADDR_ACK, else IGNORE.
REQ-019 ADDR_ACK: on scl_fall sda_oe = 1; on the next scl_fall sda_oe = 0 and go to RX (W) or TX (R); for R, tx_load pulses and the shift register loads on that same scl_fall, and sda_oe takes tx_data[7] inverted.
REQ-020 RX: 8 bits shifted MSB first; on the 8th scl_rise, rx_data updates and rx_valid pulses once, then RX_ACK.
REQ-021 RX_ACK: ACK driven low for exactly one scl period (scl_fall to scl_fall), then RX.
REQ-022 TX: sda_oe = ~bit on each scl_fall, 8 bits; after the 8th bit, release on scl_fall -> TX_ACK.
REQ-023 TX_ACK: sample sda on scl_rise; 0 (ACK) -> TX with tx_load and new byte on the next scl_fall; 1 (NACK) -> IGNORE.
REQ-024 IGNORE: sda_oe = 0; leave only on START or STOP.
REQ-025 STOP -> IDLE, sda_oe = 0, busy = 0; partial byte discarded, no rx_valid.
REQ-026 General call (address 0) is not acknowledged; clock stretching is not supported.

Reset
REQ-027 Reset forces IDLE, sda_oe = 0, rx_data = 8'h00, rx_valid = 0, tx_load = 0, busy = 0, and synchronizer/history flops = 1 (idle bus); no spurious START after release.

Structure
REQ-028 Package i2c_pkg holds the state enum, the ACK/NACK constants and the bit-count width.
REQ-029 Sub-module i2c_sync_edge (synchronizer plus rise/fall detect) is instantiated once each for scl and sda_in.

Verification
REQ-030 Write 0xA0, 0x3C at ADDR 0x50 -> ACK on addr and data, rx_valid once with rx_data = 8'h3C.
REQ-031 Address 0x51 -> no ACK (sda_oe = 0 throughout), busy = 0, no rx_valid.
REQ-032 Read 0xA1 with tx_data = 8'hC5, controller ACK then NACK -> bytes 0xC5 on SDA MSB first, tx_load twice, released after NACK.
REQ-033 Repeated START mid-RX byte after 4 bits -> ADDR, no rx_valid, new address decoded.
REQ-034 STOP during TX bit 3 -> sda_oe = 0 within SYNC_STAGES+2 clk, IDLE.
REQ-035 reset asserted mid-ACK -> sda_oe = 0 immediately, all outputs at reset values.
